// File: rtl/cipher_out_fifo.sv
// Ciphertext output FIFO: buffers plugboard letters and emits them in fixed-size groups
// with a separator code between groups, over valid/ready handshakes on both sides.
module cipher_out_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned GROUP    = 5,
  parameter logic [4:0]  SEP_CODE = 5'b00000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [4:0]                 in_letter,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [4:0]                 out_code,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned GW = 4;

  typedef enum logic [0:0] {StLetter, StSep} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [GW-1:0]   grp_cnt_q, grp_cnt_d;
  logic            drop_q, drop_d;
  logic [4:0]      mem [DEPTH];

  logic legal, push, pop;

  assign legal = (in_letter >= 5'd1) && (in_letter <= 5'd26);

  // All handshake outputs come from registered state only.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (state_q == StSep) || (count_q != '0);
  assign out_code  = (state_q == StLetter && count_q != '0) ? mem[rd_ptr_q] : SEP_CODE;
  assign count     = count_q;
  assign drop_err  = drop_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    grp_cnt_d = grp_cnt_q;
    drop_d    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    if (clear) begin
      state_d   = StLetter;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      grp_cnt_d = '0;
    end else begin
      push   = in_valid && in_ready && legal;
      drop_d = in_valid && in_ready && !legal;

      unique case (state_q)
        StLetter: begin
          pop = (count_q != '0) && out_ready;
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (grp_cnt_q == GW'(GROUP - 1)) begin
              grp_cnt_d = '0;
              state_d   = StSep;
            end else begin
              grp_cnt_d = grp_cnt_q + GW'(1);
            end
          end
        end
        StSep: begin
          if (out_ready) state_d = StLetter;
        end
        default: state_d = StLetter;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StLetter;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      grp_cnt_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      grp_cnt_q <= grp_cnt_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset; occupancy is governed by count_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_letter;
  end

endmodule

// File: tb/tb_cipher_out_fifo.sv
// Bench for cipher_out_fifo: table vectors, directed corner sequences and random traffic,
// all checked against a queue-based model of the grouping formatter.
module tb_cipher_out_fifo;

  localparam int DEPTH = 8;
  localparam int GROUP = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_letter = 5'd0;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_code;
  logic       out_ready = 1'b0;
  logic [3:0] count;
  logic       drop_err;

  int tests = 0;
  int fails = 0;

  // Model: letters waiting, letters emitted in current group, separator pending, drop pulse.
  int mq[$];
  int mg;
  bit msep;
  bit mdrop;

  typedef struct {
    logic       v;
    logic [4:0] l;
    logic       r;
    logic       c;
    int         e_cnt;
    logic       e_drop;
    logic       e_ov;
    logic [4:0] e_code;
  } vec_t;

  vec_t tbl[9];
  int   got[$];

  cipher_out_fifo #(.DEPTH(DEPTH), .GROUP(GROUP), .SEP_CODE(5'b00000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_letter (in_letter),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_ready (out_ready),
    .count     (count),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mg = 0;
    msep = 0;
    mdrop = 0;
  endtask

  task automatic compare_model();
    int ecode;
    ecode = msep ? 0 : ((mq.size() != 0) ? mq[0] : 0);
    check("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
    check("out_valid", int'(out_valid), int'(msep || mq.size() != 0));
    check("out_code", int'(out_code), ecode);
    check("count", int'(count), mq.size());
    check("drop_err", int'(drop_err), int'(mdrop));
  endtask

  task automatic model_update(input logic v, input logic [4:0] l, input logic r,
                              input logic c);
    bit acc, lg;
    if (c) begin
      model_reset();
    end else begin
      acc = v && (mq.size() != DEPTH);
      lg = (l >= 1) && (l <= 26);
      mdrop = acc && !lg;
      if (msep) begin
        if (r) msep = 0;
      end else if (mq.size() != 0 && r) begin
        void'(mq.pop_front());
        mg++;
        if (mg == GROUP) begin
          mg = 0;
          msep = 1;
        end
      end
      if (acc && lg) mq.push_back(int'(l));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic [4:0] l, input logic r, input logic c);
    compare_model();
    in_valid = v;
    in_letter = l;
    out_ready = r;
    clear = c;
    model_update(v, l, r, c);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 0;
    in_letter = 0;
    out_ready = 0;
    clear = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic check_list(input string name, input int exp[]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) check(name, got[i], exp[i]);
  endtask

  initial begin
    int hello[6] = '{8, 5, 12, 12, 15, 23};
    logic v, r, c;
    logic [4:0] l;

    tbl[0] = '{1'b1, 5'd0,  1'b0, 1'b0, 0, 1'b1, 1'b0, 5'd0};
    tbl[1] = '{1'b1, 5'd1,  1'b0, 1'b0, 1, 1'b0, 1'b1, 5'd1};
    tbl[2] = '{1'b1, 5'd27, 1'b0, 1'b0, 1, 1'b1, 1'b1, 5'd1};
    tbl[3] = '{1'b1, 5'd2,  1'b0, 1'b0, 2, 1'b0, 1'b1, 5'd1};
    tbl[4] = '{1'b1, 5'd31, 1'b0, 1'b0, 2, 1'b1, 1'b1, 5'd1};
    tbl[5] = '{1'b0, 5'd0,  1'b1, 1'b0, 1, 1'b0, 1'b1, 5'd2};
    tbl[6] = '{1'b0, 5'd0,  1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd0};
    tbl[7] = '{1'b1, 5'd3,  1'b0, 1'b0, 1, 1'b0, 1'b1, 5'd3};
    tbl[8] = '{1'b1, 5'd4,  1'b0, 1'b1, 0, 1'b0, 1'b0, 5'd0};

    // Reset state
    do_reset();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_code", int'(out_code), 0);
    check("rst_count", int'(count), 0);
    check("rst_drop", int'(drop_err), 0);

    // Table: illegal codes dropped, legal ones stored, then clear with a push
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].c);
      check("tbl_count", int'(count), tbl[i].e_cnt);
      check("tbl_drop", int'(drop_err), int'(tbl[i].e_drop));
      check("tbl_out_valid", int'(out_valid), int'(tbl[i].e_ov));
      check("tbl_out_code", int'(out_code), int'(tbl[i].e_code));
    end

    // hello-w with out_ready held high
    do_reset();
    got.delete();
    for (int i = 0; i < 10; i++) begin
      check("hello_count_le1", int'(count <= 1), 1);
      if (out_valid) got.push_back(int'(out_code));
      step(i < 6, (i < 6) ? 5'(hello[i]) : 5'd0, 1'b1, 1'b0);
    end
    check_list("hello_out", '{8, 5, 12, 12, 15, 0, 23});

    // Fill to full, refuse a 9th, then drain
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 5'(i), 1'b0, 1'b0);
    check("full_in_ready", int'(in_ready), 0);
    check("full_count", int'(count), 8);
    step(1'b1, 5'd9, 1'b0, 1'b0);
    check("full_refuse_count", int'(count), 8);
    got.delete();
    for (int i = 0; i < 11; i++) begin
      if (out_valid) got.push_back(int'(out_code));
      step(1'b0, 5'd0, 1'b1, 1'b0);
    end
    check_list("drain_out", '{1, 2, 3, 4, 5, 0, 6, 7, 8});
    check("drain_count", int'(count), 0);

    // Separator held with an empty FIFO until accepted
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 5'(i + 10), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("sep_hold_valid", int'(out_valid), 1);
      check("sep_hold_code", int'(out_code), 0);
      step(1'b0, 5'd0, 1'b0, 1'b0);
    end
    step(1'b0, 5'd0, 1'b1, 1'b0);
    check("sep_done_valid", int'(out_valid), 0);

    // Clear while in separator state with the FIFO half full
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 5'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 6; i <= 9; i++) step(1'b1, 5'(i), 1'b0, 1'b0);
    check("pre_clear_count", int'(count), 4);
    check("pre_clear_sep", int'(out_code), 0);
    step(1'b1, 5'd20, 1'b0, 1'b1);
    check("clear_count", int'(count), 0);
    check("clear_valid", int'(out_valid), 0);
    step(1'b1, 5'd21, 1'b0, 1'b0);
    check("post_clear_letter", int'(out_code), 21);

    // Asynchronous reset mid-group
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 5'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 1'b1, 1'b0);
    out_ready = 0;
    #2;
    rst_n = 0;
    #1;
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_code", int'(out_code), 0);
    check("arst_count", int'(count), 0);
    check("arst_drop", int'(drop_err), 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    got.delete();
    for (int i = 0; i < 10; i++) begin
      if (out_valid) got.push_back(int'(out_code));
      step(i < 6, (i < 6) ? 5'(i + 10) : 5'd0, 1'b1, 1'b0);
    end
    check_list("arst_group", '{10, 11, 12, 13, 14, 0, 15});

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0)
        l = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(27, 31));
      else
        l = 5'($urandom_range(1, 26));
      r = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 99) == 0);
      step(v, l, r, c);
    end
    compare_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cipher_out_fifo.md
# cipher_out_fifo

Output formatter downstream of the reverse plugboard stage on the Enigma return path. Accepts one 5-bit ciphertext letter code per handshake (a=1 … z=26) and buffers it in a small FIFO. Presents letters to the display/serial sink with a valid/ready handshake, inserting a separator code after every GROUP letters so ciphertext comes out in classic five-letter groups.

## Interface
- DEPTH, 8, FIFO capacity in letters; power of two, at least 2.
- GROUP, 5, number of letters between separators; range 1–15.
- SEP_CODE, 5'b00000, code emitted as the group separator.
- clk  input  1  rising-edge clock; the block has one clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; highest priority.
- in_valid  input  1  a letter is offered on in_letter.
- in_letter  input  5  letter code from the plugboard stage.
- in_ready  output  1  FIFO can accept a letter this cycle.
- out_valid  output  1  out_code holds a valid letter or separator.
- out_code  output  5  letter code or SEP_CODE.
- out_ready  input  1  sink accepts out_code this cycle.
- count  output  $clog2(DEPTH+1)  letters currently stored; 4 bits at default.
- drop_err  output  1  one-cycle pulse when an illegal code is discarded.

## Operation
- Push: in_valid && in_ready && legal code (1..26) writes in_letter at the write pointer.
- Illegal input: a code of 0 or 27..31 arriving with in_valid && in_ready is not stored and raises drop_err for one cycle. Pointers and count are unchanged.
- in_ready = (count != DEPTH). A full FIFO refuses input even if a pop happens in the same cycle.
- Output is first-word fall-through. States are LETTER and SEP.
- LETTER state:
  - out_valid = (count != 0); out_code = FIFO head.
  - A pop (out_valid && out_ready) advances the read pointer and increments grp_cnt.
  - When the popped letter is the GROUP-th, grp_cnt returns to 0 and the next state is SEP.
- SEP state:
  - out_valid = 1; out_code = SEP_CODE, independent of FIFO occupancy.
  - Accepting the separator (out_ready) does not touch the FIFO and returns the block to LETTER.
  - Pushes continue normally while in SEP.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- out_code and out_valid are held stable while out_valid && !out_ready.
- clear:
  - Sets count and both pointers to 0, sets grp_cnt to 0, and forces state to LETTER.
  - Any push or pop in the same cycle is ignored and drop_err is 0.
- Reset (rst_n low, at any time, including mid-group or in SEP): same result as clear, taking effect immediately. Stored data is not required to be zeroed.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_code = SEP_CODE, count = 0, drop_err = 0, state = LETTER.
- Latency: a letter pushed on edge N appears on out_code with out_valid = 1 after edge N if the FIFO was empty and the state is LETTER.
- Throughput: one letter per cycle in each direction. A group of GROUP letters costs GROUP+1 output cycles.
- drop_err asserts in the cycle after the offending edge and lasts one cycle.
- count updates on the same edge as the push or pop.
- in_ready, out_valid and out_code have no combinational path from out_ready or in_valid. All three derive from registered state only.

## Test plan
- Reset, then push "h,e,l,l,o,w" (8,5,12,12,15,23) with out_ready=1 held.
  - Required output: 8,5,12,12,15,0,23.
  - count never exceeds 1.
- Push 8 letters with out_ready=0.
  - in_ready drops after the 8th and count=8.
  - A 9th in_valid is not accepted.
  - Raise out_ready: the 8 letters drain in order, a separator follows the 5th, and count returns to 0.
- Push codes 0, 27 and 31 interleaved with 1 and 2.
  - drop_err pulses three times; only 1,2 are stored.
- Pop 5 letters with the FIFO then empty.
  - out_valid stays 1 with out_code=0 until out_ready, then goes low.
- With FIFO half full and state SEP, assert clear together with in_valid.
  - Next cycle: count=0, out_valid=0, state LETTER, no letter stored.
- Drop rst_n asynchronously mid-group after 3 letters popped.
  - Outputs go to reset values immediately.
  - After release, the next group emits 5 letters before the first separator.
